// File: rtl/twmul_arbiter_pkg.sv
// Shared FFT-8 definitions: Q8.8 data width, default lane count,
// lane-index type and the W8^1 twiddle constants (cos / -sin in Q8.8).
package fft8_pkg;

  localparam int FFT_W    = 16;
  localparam int NREQ_DEF = 4;
  localparam int LANE_W   = $clog2(NREQ_DEF);

  typedef logic [LANE_W-1:0] lane_idx_t;

  localparam logic [FFT_W-1:0] TW_C = 16'h00B4;  //  0.7031 ~ cos(pi/4)
  localparam logic [FFT_W-1:0] TW_S = 16'hFF4C;  // -0.7031 ~ -sin(pi/4)

endpackage

// File: rtl/twmul_arbiter_if.sv
// Lane request/response and shared-multiplier bus of the twiddle arbiter.
// master: the lanes plus the multiplier; slave: the arbiter itself.
interface twmul_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 16
);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic [W-1:0]      mul_a;
  logic [W-1:0]      mul_b;
  logic [W-1:0]      mul_r;
  logic [W-1:0]      mul_i;
  logic [NREQ-1:0]   rsp_valid;
  logic [W-1:0]      rsp_r;
  logic [W-1:0]      rsp_i;

  modport master (
    output req_valid, req_a, req_b, mul_r, mul_i,
    input  req_ready, mul_a, mul_b, rsp_valid, rsp_r, rsp_i
  );

  modport slave (
    input  req_valid, req_a, req_b, mul_r, mul_i,
    output req_ready, mul_a, mul_b, rsp_valid, rsp_r, rsp_i
  );

endinterface

// File: rtl/twmul_arbiter_rr.sv
// rr_arbiter: zero-latency round-robin scan starting at ptr, plus the
// priority pointer that moves to one past the last winner.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] grant,
  output logic            grant_any,
  output logic [IW-1:0]   grant_idx
);

  logic [IW-1:0] ptr_reg;

  // First valid lane in the order ptr, ptr+1, ... wrapping at NREQ.
  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_reg) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!grant_any && req_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = IW'(idx);
      end
    end
    grant[grant_idx] = grant_any;
  end

  // Pointer moves past the winner; holds when nobody is granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg <= '0;
    end else if (grant_any) begin
      if (int'(grant_idx) == NREQ - 1) ptr_reg <= '0;
      else                             ptr_reg <= grant_idx + IW'(1);
    end
  end

endmodule

// File: rtl/twmul_arbiter.sv
// twmul_arbiter: shares one W8^1 twiddle multiplier between NREQ lanes.
// Grants are same-cycle; a LAT-deep tag pipe remembers which lane owns
// each product so it can be steered back with a one-hot strobe.
// Optional build macro: TWMUL_PERF_EN adds saturating per-lane grant
// counters on perf_cnt; without it perf_cnt is constant zero.
module twmul_arbiter
  import fft8_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W    = FFT_W,
  parameter int LAT  = 1
) (
  input  logic               clk,
  input  logic               rst,
  twmul_arbiter_if.slave     bus,
  output logic               busy,
  output logic [NREQ*16-1:0] perf_cnt
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] grant;
  logic            grant_any;
  logic [IW-1:0]   grant_idx;

  logic            tag_valid_reg [LAT];
  logic [IW-1:0]   tag_idx_reg   [LAT];
  logic            inflight;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req_valid (bus.req_valid),
    .grant     (grant),
    .grant_any (grant_any),
    .grant_idx (grant_idx)
  );

  assign bus.req_ready = grant;

  // Steer the winner's operand to the multiplier; zero when idle so the
  // multiplier input is deterministic.
  always_comb begin
    bus.mul_a = '0;
    bus.mul_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        bus.mul_a = bus.req_a[i*W +: W];
        bus.mul_b = bus.req_b[i*W +: W];
      end
    end
  end

  // Ownership tags ride alongside the multiplier pipeline; reset drops
  // anything already in flight.
  genvar gi;
  generate
    for (gi = 0; gi < LAT; gi++) begin : g_tag
      if (gi == 0) begin : g_head
        // Stage 0 captures this cycle's grant.
        always_ff @(posedge clk) begin
          if (rst) begin
            tag_valid_reg[gi] <= 1'b0;
            tag_idx_reg[gi]   <= '0;
          end else begin
            tag_valid_reg[gi] <= grant_any;
            tag_idx_reg[gi]   <= grant_idx;
          end
        end
      end else begin : g_body
        // Later stages simply shift.
        always_ff @(posedge clk) begin
          if (rst) begin
            tag_valid_reg[gi] <= 1'b0;
            tag_idx_reg[gi]   <= '0;
          end else begin
            tag_valid_reg[gi] <= tag_valid_reg[gi-1];
            tag_idx_reg[gi]   <= tag_idx_reg[gi-1];
          end
        end
      end
    end
  endgenerate

  // Return the product to its owning lane; outputs are zero otherwise.
  always_comb begin
    bus.rsp_valid = '0;
    bus.rsp_r     = '0;
    bus.rsp_i     = '0;
    if (tag_valid_reg[LAT-1]) begin
      bus.rsp_valid[tag_idx_reg[LAT-1]] = 1'b1;
      bus.rsp_r = bus.mul_r;
      bus.rsp_i = bus.mul_i;
    end
  end

  // Any tag stage valid means a result is still on its way back.
  always_comb begin
    inflight = 1'b0;
    for (int s = 0; s < LAT; s++) inflight = inflight | tag_valid_reg[s];
  end

  assign busy = inflight | (|bus.req_valid);

`ifdef TWMUL_PERF_EN
  logic [15:0] cnt_reg [NREQ];

  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_perf
      // Count accepted operands per lane, sticking at the maximum.
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg[gi] <= '0;
        end else if (bus.req_valid[gi] && grant[gi] && cnt_reg[gi] != 16'hFFFF) begin
          cnt_reg[gi] <= cnt_reg[gi] + 16'd1;
        end
      end
      assign perf_cnt[gi*16 +: 16] = cnt_reg[gi];
    end
  endgenerate
`else
  assign perf_cnt = '0;
`endif

endmodule

// File: tb/tb_twmul_arbiter.sv
// Directed bench for twmul_arbiter (NREQ=4, W=16, LAT=1) with a
// one-cycle model of the W8^1 twiddle multiplier.
module tb_twmul_arbiter;
  import fft8_pkg::*;

  localparam int NREQ = 4;
  localparam int W    = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        busy;
  logic [63:0] perf_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  twmul_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

  twmul_arbiter #(.NREQ(NREQ), .W(W), .LAT(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .busy     (busy),
    .perf_cnt (perf_cnt)
  );

  always #5 clk = ~clk;

  // Reference twiddle multiplier: (a + jb) * (C + jS), Q8.8, one cycle.
  always_ff @(posedge clk) begin
    logic signed [31:0] pr;
    logic signed [31:0] pi;
    pr = $signed(bus.mul_a) * $signed(TW_C) - $signed(bus.mul_b) * $signed(TW_S);
    pi = $signed(bus.mul_a) * $signed(TW_S) + $signed(bus.mul_b) * $signed(TW_C);
    bus.mul_r <= pr[23:8];
    bus.mul_i <= pi[23:8];
  end

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  ready;
    logic [15:0] mula;
    logic [15:0] mulb;
    logic        busy;
    logic [3:0]  rsp;
    logic [15:0] r;
    logic [15:0] i;
  } vec_t;

  vec_t vecs [21];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    // Lane operands (lane 0 at the bottom):
    //   L0 a=0100 -> (00B4,FF4C)   L1 b=0100 -> (00B4,00B4)
    //   L2 a=0200 -> (0168,FE98)   L3 a=FF00 -> (FF4C,00B4)
    // Each row: inputs this cycle, combinational grant outputs this cycle,
    // and the response belonging to the previous row's grant.
    vecs[0]  = '{4'h0, 4'h0, 16'h0000, 16'h0000, 1'b0, 4'h0, 16'h0000, 16'h0000};
    vecs[1]  = '{4'h1, 4'h1, 16'h0100, 16'h0000, 1'b1, 4'h0, 16'h0000, 16'h0000};
    vecs[2]  = '{4'hF, 4'h2, 16'h0000, 16'h0100, 1'b1, 4'h1, 16'h00B4, 16'hFF4C};
    vecs[3]  = '{4'hF, 4'h4, 16'h0200, 16'h0000, 1'b1, 4'h2, 16'h00B4, 16'h00B4};
    vecs[4]  = '{4'hF, 4'h8, 16'hFF00, 16'h0000, 1'b1, 4'h4, 16'h0168, 16'hFE98};
    vecs[5]  = '{4'hF, 4'h1, 16'h0100, 16'h0000, 1'b1, 4'h8, 16'hFF4C, 16'h00B4};
    vecs[6]  = '{4'hF, 4'h2, 16'h0000, 16'h0100, 1'b1, 4'h1, 16'h00B4, 16'hFF4C};
    vecs[7]  = '{4'hF, 4'h4, 16'h0200, 16'h0000, 1'b1, 4'h2, 16'h00B4, 16'h00B4};
    vecs[8]  = '{4'hF, 4'h8, 16'hFF00, 16'h0000, 1'b1, 4'h4, 16'h0168, 16'hFE98};
    vecs[9]  = '{4'h0, 4'h0, 16'h0000, 16'h0000, 1'b1, 4'h8, 16'hFF4C, 16'h00B4};
    vecs[10] = '{4'h0, 4'h0, 16'h0000, 16'h0000, 1'b0, 4'h0, 16'h0000, 16'h0000};
    vecs[11] = '{4'h2, 4'h2, 16'h0000, 16'h0100, 1'b1, 4'h0, 16'h0000, 16'h0000};
    vecs[12] = '{4'hA, 4'h8, 16'hFF00, 16'h0000, 1'b1, 4'h2, 16'h00B4, 16'h00B4};
    vecs[13] = '{4'h2, 4'h2, 16'h0000, 16'h0100, 1'b1, 4'h8, 16'hFF4C, 16'h00B4};
    vecs[14] = '{4'hE, 4'h4, 16'h0200, 16'h0000, 1'b1, 4'h2, 16'h00B4, 16'h00B4};
    vecs[15] = '{4'h0, 4'h0, 16'h0000, 16'h0000, 1'b1, 4'h4, 16'h0168, 16'hFE98};
    vecs[16] = '{4'h0, 4'h0, 16'h0000, 16'h0000, 1'b0, 4'h0, 16'h0000, 16'h0000};
    vecs[17] = '{4'h1, 4'h1, 16'h0100, 16'h0000, 1'b1, 4'h0, 16'h0000, 16'h0000};
    vecs[18] = '{4'h1, 4'h1, 16'h0100, 16'h0000, 1'b1, 4'h1, 16'h00B4, 16'hFF4C};
    vecs[19] = '{4'h0, 4'h0, 16'h0000, 16'h0000, 1'b1, 4'h1, 16'h00B4, 16'hFF4C};
    vecs[20] = '{4'h0, 4'h0, 16'h0000, 16'h0000, 1'b0, 4'h0, 16'h0000, 16'h0000};

    bus.req_valid = '0;
    bus.req_a     = {16'hFF00, 16'h0200, 16'h0000, 16'h0100};
    bus.req_b     = {16'h0000, 16'h0000, 16'h0100, 16'h0000};

    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset perf_cnt", perf_cnt, 64'h0);

    // Table-driven section.
    for (int v = 0; v < 21; v++) begin
      if (v != 0) @(negedge clk);
      bus.req_valid = vecs[v].valid;
      #1;
      chk($sformatf("v%0d req_ready", v), 64'(bus.req_ready), 64'(vecs[v].ready));
      chk($sformatf("v%0d mul_a", v),     64'(bus.mul_a),     64'(vecs[v].mula));
      chk($sformatf("v%0d mul_b", v),     64'(bus.mul_b),     64'(vecs[v].mulb));
      chk($sformatf("v%0d busy", v),      64'(busy),          64'(vecs[v].busy));
      chk($sformatf("v%0d rsp_valid", v), 64'(bus.rsp_valid), 64'(vecs[v].rsp));
      chk($sformatf("v%0d rsp_r", v),     64'(bus.rsp_r),     64'(vecs[v].r));
      chk($sformatf("v%0d rsp_i", v),     64'(bus.rsp_i),     64'(vecs[v].i));
    end

    // Reset mid-flight: lane 2 granted in the reset cycle (ptr was 1).
    @(negedge clk);
    bus.req_valid = 4'h4;
    rst = 1'b1;
    #1;
    chk("rstmid grant", 64'(bus.req_ready), 64'h4);
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = 4'h0;
    #1;
    chk("rstmid rsp_valid", 64'(bus.rsp_valid), 64'h0);
    chk("rstmid rsp_r",     64'(bus.rsp_r),     64'h0);
    chk("rstmid rsp_i",     64'(bus.rsp_i),     64'h0);
    chk("rstmid req_ready", 64'(bus.req_ready), 64'h0);
    chk("rstmid mul_a",     64'(bus.mul_a),     64'h0);
    chk("rstmid mul_b",     64'(bus.mul_b),     64'h0);
    chk("rstmid busy",      64'(busy),          64'h0);
    chk("rstmid perf_cnt",  perf_cnt,           64'h0);
    // Pointer must be back at 0: with all lanes valid lane 0 wins.
    @(negedge clk);
    bus.req_valid = 4'hF;
    #1;
    chk("rstmid ptr0", 64'(bus.req_ready), 64'h1);
    @(negedge clk);
    bus.req_valid = 4'h0;
    #1;
    chk("rstmid post rsp_valid", 64'(bus.rsp_valid), 64'h1);
    chk("rstmid post rsp_r",     64'(bus.rsp_r),     64'h00B4);

    // Grant counters.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`ifdef TWMUL_PERF_EN
    bus.req_valid = 4'h1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.req_valid = 4'h0;
    #1;
    chk("perf lane0 count3", perf_cnt, 64'h0000_0000_0000_0003);
    bus.req_valid = 4'h1;
    repeat (70000) @(posedge clk);
    @(negedge clk);
    bus.req_valid = 4'h0;
    #1;
    chk("perf lane0 saturated", 64'(perf_cnt[15:0]), 64'hFFFF);
    chk("perf other lanes",     64'(perf_cnt[63:16]), 64'h0);
`else
    bus.req_valid = 4'hF;
    repeat (8) @(posedge clk);
    @(negedge clk);
    bus.req_valid = 4'h0;
    #1;
    chk("perf tied zero", perf_cnt, 64'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/twmul_arbiter.md
# twmul_arbiter

Round-robin arbiter that shares one W8^1 twiddle multiplier between several butterfly lanes of the 8-point FFT datapath. Each lane presents a Q8.8 complex operand with a valid/ready handshake. The arbiter drives the winner's operand into the multiplier and tracks ownership through the multiplier's pipeline latency. It then returns the product to the originating lane with a one-hot response strobe. It sits between the butterfly stages and the single shared multiplier instance.

## Interface
- NREQ, 4: number of requesting lanes (2..8).
- W, 16: operand/result width, Q8.8 signed.
- LAT, 1: multiplier latency in cycles from operand to result (≥1).
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  NREQ  lane i holds an operand.
- req_a  in  NREQ*W  real parts, lane i at [i*W +: W].
- req_b  in  NREQ*W  imaginary parts, same packing.
- req_ready  out  NREQ  one-hot grant; the operand is consumed on valid&ready.
- mul_a, mul_b  out  W  operand to the shared multiplier.
- mul_r, mul_i  in  W  multiplier result, valid LAT cycles after the operand.
- rsp_valid  out  NREQ  one-hot result strobe, single cycle.
- rsp_r, rsp_i  out  W  result, qualified by rsp_valid.
- busy  out  1  a result is in flight, or any req_valid is high.
- perf_cnt  out  NREQ*16  grant counters (see Configuration).

## Operation
- **Arbitration:**
  - The arbiter is combinational from req_valid and the priority pointer `ptr`.
  - It grants the first valid lane scanning ptr, ptr+1, … mod NREQ.
  - At most one grant per cycle.
  - There is no stall condition: if any req_valid is set, exactly one req_ready is set in that cycle.
- **Pointer update:** on a grant to lane g, ptr <= (g+1) mod NREQ. With no grant, ptr holds. Reset value is 0.
- **Operand path:**
  - mul_a/mul_b = req_a/req_b of the granted lane.
  - With no grant they are 0, so the multiplier sees a deterministic zero.
- **Lane rule:** a lane keeps valid and data stable until it sees ready. Deasserting valid before ready is allowed (the request is withdrawn) and results in no grant to that lane.
- **Tag pipeline:**
  - A LAT-deep shift register of {valid, lane index} advances every cycle.
  - Stage 0 loads {grant_any, g}.
  - When the last stage is valid: rsp_valid[idx] = 1, rsp_r = mul_r, rsp_i = mul_i.
  - Otherwise rsp_valid = 0 and rsp_r/rsp_i = 0.
- **Backpressure:** responses have none; lanes must accept rsp_valid whenever it arrives.
- **Arithmetic:** the arbiter never modifies data. Widths pass through unchanged, with no rounding or saturation in this block.
- **Reset:** every output is 0 in the cycle following a reset cycle: req_ready, mul_a/b, rsp_valid, rsp_r/i, busy, perf_cnt.

## Timing
- The grant is same-cycle with valid (zero-latency arbitration).
- An operand granted in cycle t produces rsp_valid in cycle t+LAT.
- Throughput is one operand per cycle aggregate. Back-to-back grants to different lanes produce back-to-back responses in grant order.
- A single requesting lane is granted every cycle; round-robin never starves a lone requester.
- **rst asserted mid-operation:**
  - All tag stages are cleared at the next edge.
  - In-flight results are dropped: no rsp_valid for any operand granted before the reset edge.
  - ptr returns to 0.
- **Simultaneous grant and response to the same lane:** both are legal in the same cycle and independent.
- **ptr wrap:** a grant to lane NREQ-1 sets ptr to 0.

## Configuration
- **TWMUL_PERF_EN defined:**
  - Each lane has a 16-bit grant counter, incremented on valid&ready.
  - The counter saturates at 0xFFFF and clears on rst.
  - The counters are exposed on perf_cnt.
- **TWMUL_PERF_EN undefined:** no counter logic; perf_cnt is tied to 0.

## Structure
- Shared package `fft8_pkg`:
  - Q8.8 width constant, FFT_W = 16.
  - Lane-index type, width clog2(NREQ).
  - Twiddle constants 0x00B4 / 0xFF4C.
- Sub-module `rr_arbiter` holds the priority scan and pointer register. The tag pipeline and response mux stay in the top module.

## Test plan
- **Single lane:** lane 0 holds a=0x0100, b=0x0000 with a model multiplier (LAT=1) -> req_ready[0]=1 at t; at t+1 rsp_valid=0001, rsp_r=0x00B4, rsp_i=0xFF4C.
- **All four lanes valid for 8 cycles:** grant order 0,1,2,3,0,1,2,3 -> responses in the same order, one per cycle, each carrying its lane's product.
- **Lanes 1 and 3 valid, ptr=2:** grant 3 first, then 1; ptr ends at 2.
- **Reset mid-flight:** grant lane 2 at t, rst at t -> no rsp_valid at t+1; all outputs 0; ptr=0.
- **Idle:** no req_valid -> mul_a=mul_b=0, req_ready=0, rsp_valid=0 one cycle later, busy=0.
- **TWMUL_PERF_EN:** 70000 consecutive lane-0 grants -> perf_cnt[15:0] = 0xFFFF, other lanes 0. Without the macro -> perf_cnt = 0.
